// File: rtl/scan_capture.sv
// Receive-side decoder for the 4-digit multiplexed display scan: settles each
// (enable, segment) pair, decodes it to BCD and publishes complete frames.

module bcd_seg (
  input  logic [3:0]  bcd,
  output logic [14:0] seg
);
  always_comb begin
    seg = 15'h0000;
    case (bcd)
      4'd0: seg = 15'h0E3F;
      4'd1: seg = 15'h0006;
      4'd2: seg = 15'h105B;
      4'd3: seg = 15'h104F;
      4'd4: seg = 15'h1066;
      4'd5: seg = 15'h106D;
      4'd6: seg = 15'h107D;
      4'd7: seg = 15'h0807;
      4'd8: seg = 15'h107F;
      4'd9: seg = 15'h106F;
      default: seg = 15'h0000;
    endcase
  end
endmodule

module scan_capture #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  wh_light,
  input  logic [14:0] display,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic        frame_valid,
  output logic [7:0]  err_cnt,
  output logic        stale
);

  localparam int STW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]     SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0]     SETTLE_HIT  = 4'(SETTLE - 2);
  localparam logic [STW-1:0] STALE_MAX   = STW'(TIMEOUT);

  logic [14:0] seg_ref [10];

  for (genvar g = 0; g < 10; g++) begin : g_ref
    bcd_seg u_ref (
      .bcd (4'(g)),
      .seg (seg_ref[g])
    );
  end

  logic [3:0] n_match;
  logic [3:0] dec_val;
  logic       dec_valid;

  always_comb begin
    n_match = 4'd0;
    dec_val = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (display == seg_ref[i]) begin
        n_match = n_match + 4'd1;
        dec_val = 4'(i);
      end
    end
    dec_valid = (n_match == 4'd1);
  end

  logic [3:0] en_oh;
  logic       en_legal;

  always_comb begin
    en_oh    = 4'b0000;
    en_legal = 1'b0;
    case (wh_light)
      4'b1110: begin en_oh = 4'b0001; en_legal = 1'b1; end
      4'b1101: begin en_oh = 4'b0010; en_legal = 1'b1; end
      4'b1011: begin en_oh = 4'b0100; en_legal = 1'b1; end
      4'b0111: begin en_oh = 4'b1000; en_legal = 1'b1; end
      default: begin en_oh = 4'b0000; en_legal = 1'b0; end
    endcase
  end

  logic [18:0]    pair_q, pair_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           accepted_q, accepted_d;
  logic [3:0]     mask_q, mask_d;
  logic [3:0]     shadow_q [4];
  logic [3:0]     shadow_d [4];
  logic [3:0]     digit_q [4];
  logic [3:0]     digit_d [4];
  logic           frame_valid_q, frame_valid_d;
  logic [7:0]     err_q, err_d;
  logic [STW-1:0] stale_cnt_q, stale_cnt_d;
  logic           stale_q, stale_d;

  logic same;
  logic accept_hit;
  logic accept;
  logic frame_now;

  always_comb begin
    pair_d     = {wh_light, display};
    same       = (pair_d == pair_q);
    accept_hit = same && (cnt_q == SETTLE_HIT) && !accepted_q;
    // Illegal enables still consume the dwell so they can never be accepted later.
    accept     = accept_hit && en_legal;
    frame_now  = (mask_q == 4'b1111);

    if (!same)                    cnt_d = 4'd0;
    else if (cnt_q != SETTLE_LAST) cnt_d = cnt_q + 4'd1;
    else                          cnt_d = cnt_q;

    accepted_d = same ? (accepted_q | accept_hit) : 1'b0;

    shadow_d = shadow_q;
    digit_d  = digit_q;
    err_d    = err_q;
    mask_d   = frame_now ? 4'b0000 : mask_q;

    if (frame_now) digit_d = shadow_q;

    if (accept) begin
      if (dec_valid) begin
        mask_d = mask_d | en_oh;
        for (int d = 0; d < 4; d++) begin
          if (en_oh[d]) shadow_d[d] = dec_val;
        end
      end else if (err_q != 8'hFF) begin
        err_d = err_q + 8'd1;
      end
    end

    frame_valid_d = frame_now;

    if (frame_now)                  stale_cnt_d = '0;
    else if (stale_cnt_q != STALE_MAX) stale_cnt_d = stale_cnt_q + 1'b1;
    else                            stale_cnt_d = stale_cnt_q;
    stale_d = !frame_now && (stale_cnt_d == STALE_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_q        <= '1;
      cnt_q         <= 4'd0;
      accepted_q    <= 1'b0;
      mask_q        <= 4'b0000;
      for (int d = 0; d < 4; d++) begin
        shadow_q[d] <= 4'd0;
        digit_q[d]  <= 4'd0;
      end
      frame_valid_q <= 1'b0;
      err_q         <= 8'd0;
      stale_cnt_q   <= '0;
      stale_q       <= 1'b0;
    end else begin
      pair_q        <= pair_d;
      cnt_q         <= cnt_d;
      accepted_q    <= accepted_d;
      mask_q        <= mask_d;
      shadow_q      <= shadow_d;
      digit_q       <= digit_d;
      frame_valid_q <= frame_valid_d;
      err_q         <= err_d;
      stale_cnt_q   <= stale_cnt_d;
      stale_q       <= stale_d;
    end
  end

  assign digit0      = digit_q[0];
  assign digit1      = digit_q[1];
  assign digit2      = digit_q[2];
  assign digit3      = digit_q[3];
  assign frame_valid = frame_valid_q;
  assign err_cnt     = err_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_scan_capture.sv
// Directed bench for scan_capture: nominal scan, glitches, invalid patterns,
// illegal enables, settle boundary, reset mid-frame and staleness.

module tb_scan_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wh_light;
  logic [14:0] display;
  logic [3:0]  digit0, digit1, digit2, digit3;
  logic        frame_valid;
  logic [7:0]  err_cnt;
  logic        stale;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fv_cnt   = 0;
  int fv_cyc   = 0;
  int fv_stale = 0;
  int last_start;
  int fv0;

  scan_capture #(.SETTLE(4), .TIMEOUT(100)) dut (
    .clk         (clk),
    .rst         (rst),
    .wh_light    (wh_light),
    .display     (display),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .frame_valid (frame_valid),
    .err_cnt     (err_cnt),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt++;
      fv_cyc   = cyc;
      fv_stale = int'(stale);
    end
  end

  function automatic logic [14:0] seg_of(input int n);
    case (n)
      0: return 15'h0E3F;
      1: return 15'h0006;
      2: return 15'h105B;
      3: return 15'h104F;
      4: return 15'h1066;
      5: return 15'h106D;
      6: return 15'h107D;
      7: return 15'h0807;
      8: return 15'h107F;
      9: return 15'h106F;
      default: return 15'h0000;
    endcase
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic show(input int pos, input logic [14:0] pat, input int n);
    logic [3:0] oh;
    oh         = 4'b0001 << pos;
    wh_light   = ~oh;
    display    = pat;
    last_start = cyc;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic blank(input int n);
    wh_light = 4'b1111;
    display  = 15'h0000;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_digits(input string tag, input int a, input int b, input int c, input int d);
    check({tag, "_d0"}, int'(digit0), a);
    check({tag, "_d1"}, int'(digit1), b);
    check({tag, "_d2"}, int'(digit2), c);
    check({tag, "_d3"}, int'(digit3), d);
  endtask

  initial begin
    int stale_cyc;
    bit found;

    rst      = 1'b1;
    wh_light = 4'b1111;
    display  = 15'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_digits", int'({digit3, digit2, digit1, digit0}), 0);
    check("rst_fv", int'(frame_valid), 0);
    check("rst_err", int'(err_cnt), 0);
    check("rst_stale", int'(stale), 0);
    @(posedge clk);
    #1;

    // nominal scan 3,1,4,1
    fv0 = fv_cnt;
    show(0, seg_of(3), 16);
    show(1, seg_of(1), 16);
    show(2, seg_of(4), 16);
    show(3, seg_of(1), 16);
    blank(4);
    check("nom_fv_count", fv_cnt - fv0, 1);
    check("nom_fv_latency", fv_cyc - last_start, 5);
    check_digits("nom", 3, 1, 4, 1);
    check("nom_err", int'(err_cnt), 0);

    // short glitches ahead of each dwell must be ignored
    fv0 = fv_cnt;
    show(0, 15'h7FFF, 2); show(0, seg_of(3), 16);
    show(1, 15'h7FFF, 2); show(1, seg_of(1), 16);
    show(2, 15'h7FFF, 2); show(2, seg_of(4), 16);
    show(3, 15'h7FFF, 2); show(3, seg_of(1), 16);
    blank(4);
    check("gl_fv_count", fv_cnt - fv0, 1);
    check_digits("gl", 3, 1, 4, 1);
    check("gl_err", int'(err_cnt), 0);

    // undecodable digit2 blocks the frame; next valid digit2 completes it
    fv0 = fv_cnt;
    show(0, seg_of(2), 16);
    show(1, seg_of(7), 16);
    show(2, 15'h0000, 16);
    show(3, seg_of(5), 16);
    blank(4);
    check("inv_err", int'(err_cnt), 1);
    check("inv_no_frame", fv_cnt - fv0, 0);
    show(0, seg_of(6), 16);
    show(1, seg_of(9), 16);
    show(2, seg_of(0), 16);
    check("inv_frame", fv_cnt - fv0, 1);
    check_digits("inv", 6, 9, 0, 5);
    show(3, seg_of(8), 16);
    blank(4);
    check("inv_no_second", fv_cnt - fv0, 1);

    // illegal enables: no acceptance, mask keeps digit3 from above
    fv0 = fv_cnt;
    wh_light = 4'b1100; display = 15'h0000;
    repeat (20) @(posedge clk);
    #1;
    wh_light = 4'b1111; display = seg_of(5);
    repeat (20) @(posedge clk);
    #1;
    check("ill_err", int'(err_cnt), 1);
    check("ill_no_frame", fv_cnt - fv0, 0);
    show(0, seg_of(1), 16);
    show(1, seg_of(2), 16);
    show(2, seg_of(3), 16);
    blank(4);
    check("ill_frame", fv_cnt - fv0, 1);
    check_digits("ill", 1, 2, 3, 8);

    // dwell of SETTLE-1 edges is rejected, SETTLE edges accepted
    show(0, 15'h0000, 3);
    blank(5);
    check("bnd_short", int'(err_cnt), 1);
    show(0, 15'h0000, 4);
    blank(5);
    check("bnd_exact", int'(err_cnt), 2);

    // reset mid-frame
    fv0 = fv_cnt;
    show(0, seg_of(4), 16);
    show(1, seg_of(5), 16);
    show(2, seg_of(6), 16);
    blank(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_digits", int'({digit3, digit2, digit1, digit0}), 0);
    check("mrst_err", int'(err_cnt), 0);
    check("mrst_fv", int'(frame_valid), 0);
    check("mrst_stale", int'(stale), 0);
    @(posedge clk);
    #1;
    show(3, seg_of(7), 16);
    blank(4);
    check("mrst_no_frame", fv_cnt - fv0, 0);
    show(0, seg_of(1), 16);
    show(1, seg_of(2), 16);
    show(2, seg_of(3), 16);
    blank(2);
    check("mrst_frame", fv_cnt - fv0, 1);
    check_digits("mrst", 1, 2, 3, 7);

    // staleness: rises 100 cycles after the last frame, saturates, clears on frame
    found     = 1'b0;
    stale_cyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (stale && !found) begin
        found     = 1'b1;
        stale_cyc = cyc;
      end
    end
    check("stale_seen", int'(found), 1);
    check("stale_delay", stale_cyc - fv_cyc, 100);
    check("stale_sat", int'(stale), 1);
    @(posedge clk);
    #1;
    fv0 = fv_cnt;
    show(0, seg_of(9), 16);
    show(1, seg_of(8), 16);
    show(2, seg_of(7), 16);
    check("stale_hold", int'(stale), 1);
    show(3, seg_of(6), 16);
    blank(4);
    check("stale_frame", fv_cnt - fv0, 1);
    check("stale_clear_on_fv", fv_stale, 0);
    check_digits("stale", 9, 8, 7, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
